univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register with an auto-serialising transfer engine. It supports hold, parallel load, shift right and shift left on an NBITS-wide register. A start-triggered burst mode loads a word and shifts it out LSB-first with busy/done handshaking. It sits between the switch/LED front end and any serial consumer, and generalises the fixed 4-bit parallel/serial register.

## Interface
- NBITS, 8, register width; legal range 2..32
- CNT_W, $clog2(NBITS), width of the internal bit counter (derived; do not override)
- clk_2  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- mode  in  2  00 hold, 01 parallel load, 10 shift right, 11 shift left
- rotate  in  1  selects wrap-around instead of serial input on shifts (see Configuration)
- sin_msb  in  1  bit entering q[NBITS-1] on shift right
- sin_lsb  in  1  bit entering q[0] on shift left
- par_in  in  NBITS  parallel load data
- start  in  1  request a serial burst of par_in
- q  out  NBITS  register contents
- sout_lsb  out  1  equals q[0]
- sout_msb  out  1  equals q[NBITS-1]
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- The FSM has two states, IDLE and XFER. The bit counter (CNT_W bits) is used only in XFER.
- **IDLE, start=1:**
  - q <= par_in, count <= 0, state <= XFER, busy <= 1.
  - mode is ignored on this edge.
- **IDLE, start=0:** mode acts as follows.
  - 00: q holds.
  - 01: q <= par_in.
  - 10: q <= {sin_msb, q[NBITS-1:1]}.
  - 11: q <= {q[NBITS-2:0], sin_lsb}.
- **XFER:** mode and start are ignored.
  - If count != NBITS-1: shift right with sin_msb entering the MSB, and count <= count+1.
  - If count == NBITS-1: q holds, state <= IDLE, busy <= 0, done <= 1.
- done is 0 in every cycle other than the one following the final XFER edge.
- A start that arrives while busy=1 is dropped; it is not queued.
- A start in the cycle where done=1 (state is already IDLE) is accepted, so bursts can run back-to-back.
- sout_lsb and sout_msb are combinational taps of q.

## Timing
- **Reset:** while reset_n=0, independent of the clock:
  - q=0, state=IDLE, count=0, busy=0, done=0, so sout_lsb=sout_msb=0.
  - Release is synchronous to the next clk_2 edge.
  - Reset asserted mid-burst aborts the burst, and no done pulse is generated.
- **Mode operations:** 1-cycle latency; q reflects the operation after the edge where it was sampled.
- **Burst started at edge t:**
  - par_in[k] appears on sout_lsb after edge t+k, for k=0..NBITS-1.
  - busy=1 after edges t .. t+NBITS-1.
  - After edge t+NBITS: busy=0 and done=1 for exactly one cycle.
  - Burst length is NBITS+1 cycles from start to the done pulse.
- **Counter:** never exceeds NBITS-1, so no wrap-around occurs inside a burst.

## Configuration
- Macro: USR_ROTATE_EN.
- **Defined:** rotate=1 replaces the serial input with the wrapped bit.
  - Shift right: q <= {q[0], q[NBITS-1:1]}.
  - Shift left: q <= {q[NBITS-2:0], q[NBITS-1]}.
  - Applies to mode 10, mode 11 and XFER shifts. In XFER, rotate is sampled on every shift edge.
- **Not defined:** the rotate port exists but is ignored, and shifts always use sin_msb/sin_lsb.

## Structure
- Package usr_pkg contains:
  - typedef enum logic [1:0] mode_e: MODE_HOLD, MODE_LOAD, MODE_SHR, MODE_SHL.
  - typedef enum logic state_e: ST_IDLE, ST_XFER.
- One sub-module, usr_bit_counter: a CNT_W-bit counter with clear, enable and a terminal flag at NBITS-1, using the same clk_2/reset_n.
- The datapath mux and the FSM stay in univ_shift_reg.

## Test plan
All scenarios use NBITS=8.
- Reset mid-burst:
  - Stimulus: start with par_in=8'hA5, then drop reset_n after 3 cycles.
  - Required: q=0, busy=0 and done=0 immediately; no done pulse afterwards.
- Modes:
  - Load 8'h3C (mode 01), then mode 10 with sin_msb=1 gives 8'h9E.
  - Then mode 11 with sin_lsb=0 gives 8'h3C.
  - Then mode 00 for 3 cycles keeps 8'h3C.
- Burst:
  - Stimulus: start with par_in=8'hB4.
  - Required: sout_lsb sequence 0,0,1,0,1,1,0,1 over cycles t..t+7; busy high 8 cycles; done high exactly at t+8.
- Start while busy:
  - Stimulus: pulse start with par_in=8'hFF at t+3 of a burst of 8'h01.
  - Required: the burst is unaffected and exactly one done pulse occurs.
- Back-to-back:
  - Stimulus: start asserted during the done cycle with par_in=8'h5A.
  - Required: second burst begins, busy rises the next cycle, and the sout_lsb sequence is 0,1,0,1,1,0,1,0.
- Rotate:
  - Stimulus: q=8'h81, mode 11, rotate=1, sin_lsb=0.
  - Required: 8'h03 with USR_ROTATE_EN defined; 8'h02 without it.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register slice.
// Used by univ_shift_reg and usr_bit_counter.

package usr_pkg;

  // Operation requested on the mode port while the engine is idle
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  // Burst engine states: idle (mode ops allowed) or serialising a word
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Legal register widths
  localparam int USR_NBITS_MIN = 2;
  localparam int USR_NBITS_MAX = 32;

endpackage : usr_pkg

// File: rtl/usr_bit_counter.sv
// Bit counter for the serial burst engine.
// Counts 0..NBITS-1 and raises terminal on the last bit; it never wraps
// because enable is ignored once the terminal value is reached.

module usr_bit_counter
  import usr_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int CNT_W = $clog2(NBITS)
) (
  input  logic clk_2,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  logic [CNT_W-1:0] count;

  // Clear has priority; increments stop at the terminal value
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule : usr_bit_counter

// File: rtl/univ_shift_reg.sv
// Universal shift register with a start-triggered LSB-first burst engine.
// Optional feature macro: USR_ROTATE_EN (rotate port selects wrap-around
// on shifts); without it the rotate port is accepted but has no effect.

module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int CNT_W = $clog2(NBITS)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [NBITS-1:0] par_in,
  input  logic             start,
  output logic [NBITS-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           state_next;
  logic [NBITS-1:0] q_next;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_term;
  logic             rot_en;
  logic             shr_in;
  logic             shl_in;

`ifdef USR_ROTATE_EN
  assign rot_en = rotate;
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign rot_en        = 1'b0;
`endif

  // Bits entering each end: the serial inputs, or the wrapped bit when rotating
  assign shr_in = rot_en ? q[0]       : sin_msb;
  assign shl_in = rot_en ? q[NBITS-1] : sin_lsb;

  usr_bit_counter #(
    .NBITS (NBITS),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk_2    (clk_2),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term)
  );

  // FSM state register
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start launches a burst, the terminal count ends it
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)    state_next = ST_XFER;
      ST_XFER: if (cnt_term) state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy and counter control
  always_comb begin
    busy      = (state == ST_XFER);
    cnt_clear = (state == ST_IDLE) && start;
    cnt_en    = (state == ST_XFER) && !cnt_term;
  end

  // Datapath mux: start beats mode in idle; bursts shift right until the last bit
  always_comb begin
    q_next = q;
    if (state == ST_IDLE) begin
      if (start) begin
        q_next = par_in;
      end else begin
        case (mode_e'(mode))
          MODE_HOLD: q_next = q;
          MODE_LOAD: q_next = par_in;
          MODE_SHR:  q_next = {shr_in, q[NBITS-1:1]};
          MODE_SHL:  q_next = {q[NBITS-2:0], shl_in};
          default:   q_next = q;
        endcase
      end
    end else if (!cnt_term) begin
      q_next = {shr_in, q[NBITS-1:1]};
    end
  end

  // Shift register storage
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // One-cycle done pulse on the edge that leaves XFER
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_XFER) && cnt_term;
    end
  end

  assign sout_lsb = q[0];
  assign sout_msb = q[NBITS-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg with NBITS=8.
// Table-driven mode vectors plus hand-written burst, back-to-back,
// start-while-busy and reset-mid-burst sequences.

module tb_univ_shift_reg;

  logic       clk_2;
  logic       reset_n;
  logic [1:0] mode;
  logic       rotate;
  logic       sin_msb;
  logic       sin_lsb;
  logic [7:0] par_in;
  logic       start;
  logic [7:0] q;
  logic       sout_lsb;
  logic       sout_msb;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic       rotate;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] par_in;
    logic [7:0] exp_q;
  } vec_t;

  univ_shift_reg #(
    .NBITS (8)
  ) dut (
    .clk_2    (clk_2),
    .reset_n  (reset_n),
    .mode     (mode),
    .rotate   (rotate),
    .sin_msb  (sin_msb),
    .sin_lsb  (sin_lsb),
    .par_in   (par_in),
    .start    (start),
    .q        (q),
    .sout_lsb (sout_lsb),
    .sout_msb (sout_msb),
    .busy     (busy),
    .done     (done)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_2);
    mode    = v.mode;
    rotate  = v.rotate;
    sin_msb = v.sin_msb;
    sin_lsb = v.sin_lsb;
    par_in  = v.par_in;
    start   = 1'b0;
    @(posedge clk_2);
    #1;
  endtask

  // Burst of 'data' started on the next edge; optionally pokes start with 8'hFF at t+3.
  // Returns at t+8 sampling point (done cycle) so a caller can chain another burst.
  task automatic runBurst(input logic [7:0] data, input bit poke, input string tag);
    @(negedge clk_2);
    start   = 1'b1;
    par_in  = data;
    mode    = 2'b11;
    sin_msb = 1'b0;
    rotate  = 1'b0;
    @(posedge clk_2);
    #1;
    checkOutput($sformatf("%s_lsb0", tag), 32'(sout_lsb), 32'(data[0]));
    checkOutput($sformatf("%s_busy0", tag), 32'(busy), 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk_2);
      start  = poke && (k == 3);
      par_in = (poke && (k == 3)) ? 8'hFF : data;
      if (k == 7) mode = 2'b00;
      @(posedge clk_2);
      #1;
      checkOutput($sformatf("%s_lsb%0d", tag, k), 32'(sout_lsb), 32'(data[k]));
      checkOutput($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      checkOutput($sformatf("%s_done%0d", tag, k), 32'(done), 32'd0);
    end
    @(negedge clk_2);
    start = 1'b0;
    @(posedge clk_2);
    #1;
    checkOutput($sformatf("%s_done_pulse", tag), 32'(done), 32'd1);
    checkOutput($sformatf("%s_busy_end", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s_q_end", tag), 32'(q), 32'({7'b0, data[7]}));
  endtask

  // Trailing idle cycles: no further done pulse, no stray burst, q held
  task automatic checkQuiet(input int cycles, input logic [7:0] exp_q, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_2);
      #1;
      checkOutput($sformatf("%s_done_q%0d", tag, c), 32'(done), 32'd0);
      checkOutput($sformatf("%s_busy_q%0d", tag, c), 32'(busy), 32'd0);
      checkOutput($sformatf("%s_hold_q%0d", tag, c), 32'(q), 32'(exp_q));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    logic [7:0] rot_shl_exp;
    logic [7:0] rot_shr_exp;

`ifdef USR_ROTATE_EN
    rot_shl_exp = 8'h03;
    rot_shr_exp = 8'hC0;
`else
    rot_shl_exp = 8'h02;
    rot_shr_exp = 8'h40;
`endif

    //             mode   rot   smsb  slsb  par_in exp_q
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vecs[1]  = '{2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h9E};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
    vecs[3]  = '{2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[4]  = '{2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[5]  = '{2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[6]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 8'h00, rot_shl_exp};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[9]  = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h00, rot_shr_exp};
    vecs[10] = '{2'b11, 1'b0, 1'b0, 1'b1, 8'h00, 8'h81};
    vecs[11] = '{2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40};

    reset_n = 1'b0;
    mode    = 2'b00;
    rotate  = 1'b0;
    sin_msb = 1'b0;
    sin_lsb = 1'b0;
    par_in  = 8'h00;
    start   = 1'b0;

    #3;
    checkOutput("reset_q", 32'(q), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_taps", 32'({sout_msb, sout_lsb}), 32'd0);

    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_lsb", i), 32'(sout_lsb), 32'(vecs[i].exp_q[0]));
      checkOutput($sformatf("vec%0d_msb", i), 32'(sout_msb), 32'(vecs[i].exp_q[7]));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end

    $display("[TB] burst B4 followed back-to-back by 5A");
    runBurst(8'hB4, 1'b0, "b4");
    runBurst(8'h5A, 1'b0, "b2b");
    checkQuiet(3, 8'h00, "b2b");

    $display("[TB] burst 01 with start poked while busy");
    runBurst(8'h01, 1'b1, "poke");
    checkQuiet(4, 8'h00, "poke");

    $display("[TB] reset asserted mid-burst");
    @(negedge clk_2);
    start  = 1'b1;
    par_in = 8'hA5;
    @(posedge clk_2);
    @(negedge clk_2);
    start = 1'b0;
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_q", 32'(q), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;
    checkQuiet(12, 8'h00, "mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_univ_shift_reg
